usc_s2b_window: RTL

Windowed stochastic-to-binary converter for the scaler SFFT datapath. It sits directly downstream of the scaled stochastic adder: it consumes that adder's single-bit output stream and counts ones over a fixed window of 2^BITWIDTH enabled cycles. It then presents the count as a binary word with a done flag, either as unipolar magnitude or as bipolar signed value. It is the measurement point where butterfly results leave the stochastic domain.

---
 rtl/usc_s2b_window.sv | 100 ++++++++++
 1 files changed

// File: rtl/usc_s2b_window.sv
// Windowed stochastic-to-binary converter: counts ones over 2^BITWIDTH enabled samples.
// Define USC_S2B_BIPOLAR_EN to get a signed (ones - L/2) result instead of the unipolar count.
module usc_s2b_window #(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iStart,
   input  logic                iEn,
   input  logic                iA,
   output logic [BITWIDTH:0]   oB,
   output logic                oDone,
   output logic                oBusy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [BITWIDTH:0] WIN_LAST = {1'b0, {BITWIDTH{1'b1}}};
   localparam logic [BITWIDTH:0] CNT_ZERO = {(BITWIDTH+1){1'b0}};
   localparam logic [BITWIDTH:0] CNT_ONE  = {{BITWIDTH{1'b0}}, 1'b1};
`ifdef USC_S2B_BIPOLAR_EN
   localparam logic [BITWIDTH:0] HALF_WIN = {2'b01, {(BITWIDTH-1){1'b0}}};
`endif

   state_t              state_r;
   logic [BITWIDTH:0]   smp_r;
   logic [BITWIDTH:0]   ones_r;
   logic [BITWIDTH:0]   ones_next_s;

   // Maps the final ones count onto the output encoding.
   function automatic logic [BITWIDTH:0] to_result(input logic [BITWIDTH:0] cnt);
`ifdef USC_S2B_BIPOLAR_EN
      return cnt - HALF_WIN;
`else
      return cnt;
`endif
   endfunction

   assign ones_next_s = ones_r + {{BITWIDTH{1'b0}}, iA};

   // Window control FSM with registered result and status outputs.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_r <= ST_IDLE;
         smp_r   <= CNT_ZERO;
         ones_r  <= CNT_ZERO;
         oB      <= CNT_ZERO;
         oDone   <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (iStart) begin
                  state_r <= ST_RUN;
                  smp_r   <= CNT_ZERO;
                  ones_r  <= CNT_ZERO;
                  oBusy   <= 1'b1;
               end
            end
            ST_RUN: begin
               if (iStart) begin
                  // Abort: the sample on this cycle belongs to neither window.
                  smp_r  <= CNT_ZERO;
                  ones_r <= CNT_ZERO;
               end else if (iEn) begin
                  smp_r  <= smp_r + CNT_ONE;
                  ones_r <= ones_next_s;
                  if (smp_r == WIN_LAST) begin
                     oB      <= to_result(ones_next_s);
                     oDone   <= 1'b1;
                     oBusy   <= 1'b0;
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (iStart) begin
                  state_r <= ST_RUN;
                  smp_r   <= CNT_ZERO;
                  ones_r  <= CNT_ZERO;
                  oDone   <= 1'b0;
                  oBusy   <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               smp_r   <= CNT_ZERO;
               ones_r  <= CNT_ZERO;
               oDone   <= 1'b0;
               oBusy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
